// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR serializer/deserializer pair: FSM state
// encoding and a constant-foldable clog2 used for counter sizing.
package ddr_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ddr_ser.sv
// Parallel-to-DDR serializer: CLKDV*4-bit words in, one bit pair per CLK out.
// Define DDR_SER_LSB_FIRST_EN to emit the word LSB-first instead of MSB-first.
module ddr_ser
    import ddr_pkg::*;
#(
    parameter int   CLKDV    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 ENABLE,
    input  logic [CLKDV*4-1:0]   DATA,
    input  logic                 DATA_VALID,
    output logic                 DATA_READY,
    output logic [1:0]           DDR_OUT,
    output logic                 BUSY,
    output logic                 UNDERRUN
);

    localparam int              W         = CLKDV * 4;
    localparam int              CW        = (clog2(CLKDV * 2) > 1) ? clog2(CLKDV * 2) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKDV * 2 - 1);
    localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [1:0]      IDLE_PAIR = {IDLE_BIT, IDLE_BIT};

    logic [0:0]    state_r;
    logic [W-1:0]  sr_r;
    logic [CW-1:0] cnt_r;

    logic          word_end_s;
    logic          handshake_s;
    logic [1:0]    load_pair_s;
    logic [1:0]    shift_pair_s;
    logic [W-1:0]  load_sr_s;
    logic [W-1:0]  shift_sr_s;

    // Handshake: a new word is taken while idle or on the last pair of a word.
    always_comb begin
        word_end_s  = (state_r == ST_SHIFT) && (cnt_r == CNT_ZERO);
        DATA_READY  = ENABLE && ((state_r == ST_IDLE) || word_end_s);
        handshake_s = DATA_VALID && DATA_READY;
    end

    // Bit ordering; the earlier bit of each pair always lands on DDR_OUT[1].
    always_comb begin
`ifdef DDR_SER_LSB_FIRST_EN
        load_pair_s  = {DATA[0], DATA[1]};
        load_sr_s    = DATA >> 2'd2;
        shift_pair_s = {sr_r[0], sr_r[1]};
        shift_sr_s   = sr_r >> 2'd2;
`else
        load_pair_s  = DATA[W-1:W-2];
        load_sr_s    = DATA << 2'd2;
        shift_pair_s = sr_r[W-1:W-2];
        shift_sr_s   = sr_r << 2'd2;
`endif
    end

    // Serializer FSM, shift register, pair counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= ST_IDLE;
            sr_r     <= {W{1'b0}};
            cnt_r    <= CNT_ZERO;
            DDR_OUT  <= IDLE_PAIR;
            BUSY     <= 1'b0;
            UNDERRUN <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (handshake_s) begin
                        state_r <= ST_SHIFT;
                        sr_r    <= load_sr_s;
                        cnt_r   <= CNT_LAST;
                        DDR_OUT <= load_pair_s;
                        BUSY    <= 1'b1;
                    end else begin
                        DDR_OUT <= IDLE_PAIR;
                        BUSY    <= 1'b0;
                    end
                    UNDERRUN <= 1'b0;
                end
                ST_SHIFT: begin
                    if (cnt_r != CNT_ZERO) begin
                        sr_r     <= shift_sr_s;
                        cnt_r    <= cnt_r - CNT_ONE;
                        DDR_OUT  <= shift_pair_s;
                        UNDERRUN <= 1'b0;
                    end else if (handshake_s) begin
                        // Seamless reload: no idle pair between words.
                        sr_r     <= load_sr_s;
                        cnt_r    <= CNT_LAST;
                        DDR_OUT  <= load_pair_s;
                        BUSY     <= 1'b1;
                        UNDERRUN <= 1'b0;
                    end else begin
                        state_r  <= ST_IDLE;
                        DDR_OUT  <= IDLE_PAIR;
                        BUSY     <= 1'b0;
                        UNDERRUN <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    sr_r     <= {W{1'b0}};
                    cnt_r    <= CNT_ZERO;
                    DDR_OUT  <= IDLE_PAIR;
                    BUSY     <= 1'b0;
                    UNDERRUN <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_ser.sv
// Scoreboard bench for ddr_ser (CLKDV=4): expected pairs are queued at each
// handshake and popped by a monitor on every busy cycle.
module tb_ddr_ser;

    localparam int CLKDV = 4;
    localparam int W     = CLKDV * 4;
    localparam int NPAIR = CLKDV * 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ENABLE;
    logic [W-1:0]  DATA;
    logic          DATA_VALID;
    logic          DATA_READY;
    logic [1:0]    DDR_OUT;
    logic          BUSY;
    logic          UNDERRUN;

    int            checks   = 0;
    int            failures = 0;
    int            ur_cnt   = 0;
    bit            mon_en   = 1'b0;
    logic [1:0]    exp_q[$];
    int            waited;

    ddr_ser #(.CLKDV(CLKDV), .IDLE_BIT(1'b0)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ENABLE     (ENABLE),
        .DATA       (DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .DDR_OUT    (DDR_OUT),
        .BUSY       (BUSY),
        .UNDERRUN   (UNDERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected pair sequence for one word, earlier bit of each pair in [1].
    task automatic push_word(input logic [W-1:0] d);
        for (int i = 0; i < NPAIR; i++) begin
`ifdef DDR_SER_LSB_FIRST_EN
            exp_q.push_back({d[2*i], d[2*i+1]});
`else
            exp_q.push_back({d[W-1-2*i], d[W-2-2*i]});
`endif
        end
    endtask

    // Monitor: compare every busy cycle against the scoreboard.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (UNDERRUN) begin
                ur_cnt = ur_cnt + 1;
                check_val("underrun_idle", {30'd0, BUSY, (exp_q.size() == 0)}, 32'd1);
            end
            if (BUSY) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_empty", 32'd1, 32'd0);
                end else begin
                    check_val("pair", {30'd0, DDR_OUT}, {30'd0, exp_q.pop_front()});
                end
            end else begin
                check_val("idle_pair", {30'd0, DDR_OUT}, 32'd0);
            end
        end
    end

    // Offer a word at a negedge; returns at the negedge after the handshake.
    task automatic send_word(input logic [W-1:0] d, input bit keep_valid, output int n);
        DATA       = d;
        DATA_VALID = 1'b1;
        n = 0;
        while (!DATA_READY && n < 40) begin
            @(negedge CLK);
            n = n + 1;
        end
        if (!DATA_READY) begin
            check_val("ready_timeout", 32'd0, 32'd1);
            DATA_VALID = 1'b0;
        end else begin
            push_word(d);
            @(posedge CLK);
            @(negedge CLK);
            if (!keep_valid) begin
                DATA_VALID = 1'b0;
                DATA       = 16'hDEAD;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((BUSY || exp_q.size() != 0) && n < 60) begin
            @(negedge CLK);
            n = n + 1;
        end
        check_val("idle_reached", {31'd0, BUSY}, 32'd0);
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; ENABLE = 1'b0; DATA = 16'h0000; DATA_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        check_val("rst_ddr_out", {30'd0, DDR_OUT}, 32'd0);
        check_val("rst_busy", {31'd0, BUSY}, 32'd0);
        check_val("rst_underrun", {31'd0, UNDERRUN}, 32'd0);
        check_val("rst_ready_en0", {31'd0, DATA_READY}, 32'd0);
        ENABLE = 1'b1;
        #1;
        check_val("rst_ready_en1", {31'd0, DATA_READY}, 32'd1);
        @(negedge CLK);
        RST = 1'b0;
        mon_en = 1'b1;
        @(negedge CLK);

        // Single word followed by underrun.
        ur_cnt = 0;
        send_word(16'hA5C3, 1'b0, waited);
        check_val("single_wait", waited, 32'd0);
        wait_idle();
        check_val("single_underrun", ur_cnt, 32'd1);

        // Back-to-back words with DATA_VALID held high.
        ur_cnt = 0;
        send_word(16'hA5C3, 1'b1, waited);
        send_word(16'hFFFF, 1'b0, waited);
        check_val("b2b_ready_gap", waited, 32'd7);
        wait_idle();
        check_val("b2b_underrun", ur_cnt, 32'd1);

        // ENABLE dropped mid-word with DATA_VALID still high.
        ur_cnt = 0;
        send_word(16'h1234, 1'b1, waited);
        @(negedge CLK);
        ENABLE = 1'b0;
        wait_idle();
        check_val("en_drop_underrun", ur_cnt, 32'd1);
        check_val("en_drop_ready", {31'd0, DATA_READY}, 32'd0);
        repeat (10) @(negedge CLK);
        check_val("valid_no_en_busy", {31'd0, BUSY}, 32'd0);
        check_val("valid_no_en_ur", ur_cnt, 32'd1);
        DATA_VALID = 1'b0;
        ENABLE = 1'b1;
        @(negedge CLK);

        // Reset mid-word: abort, idle next cycle, no underrun.
        ur_cnt = 0;
        send_word(16'hA5C3, 1'b0, waited);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_val("rst_mid_ddr_out", {30'd0, DDR_OUT}, 32'd0);
        check_val("rst_mid_busy", {31'd0, BUSY}, 32'd0);
        check_val("rst_mid_flushed", exp_q.size(), 32'd4);
        exp_q.delete();
        repeat (4) @(negedge CLK);
        check_val("rst_mid_underrun", ur_cnt, 32'd0);

        // Next word restarts from its first pair; then a random word.
        ur_cnt = 0;
        send_word(16'hA5C3, 1'b0, waited);
        wait_idle();
        send_word(16'($urandom_range(0, 65535)), 1'b0, waited);
        wait_idle();
        check_val("restart_underrun", ur_cnt, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr_ser.md
Name: ddr_ser

Overview:
- Parallel-to-DDR serializer: accepts CLKDV*4-bit words over a valid/ready handshake and emits them as 2 bits per CLK cycle.
- Output pair DDR_OUT[1:0] drives a vendor ODDR in the top-level wrapper: DDR_OUT[1] goes to the rising edge, DDR_OUT[0] to the falling edge.
- Bit order is MSB-first with the rising-edge bit first, so the word round-trips unchanged through the existing DDR deserializer.

Parameters:
- CLKDV, 4, word width = CLKDV*4 bits; one word takes CLKDV*2 CLK cycles.
- IDLE_BIT, 1'b0, line level driven on both DDR_OUT bits while idle.

Ports:
- CLK  input  1  serializer clock; one bit per edge on the output side.
- RST  input  1  synchronous, active-high reset.
- ENABLE  input  1  permits acceptance of new words.
- DATA  input  CLKDV*4  parallel word.
- DATA_VALID  input  1  DATA holds a word.
- DATA_READY  output  1  word accepted on an edge where DATA_VALID && DATA_READY.
- DDR_OUT  output  2  [1] = rising-edge bit, [0] = falling-edge bit.
- BUSY  output  1  a word is being shifted.
- UNDERRUN  output  1  one-cycle pulse when the stream ends without a following word.

Behaviour:
- Width and counter
  - W = CLKDV*4.
  - Shift register SR[W-1:0].
  - Pair counter CNT of width clog2(CLKDV*2), counting down from CLKDV*2-1 to 0.
- Reset (synchronous): state=IDLE, SR=0, CNT=0, DDR_OUT={IDLE_BIT,IDLE_BIT}, BUSY=0, UNDERRUN=0.
- States: IDLE, SHIFT.
- DATA_READY is combinational: ENABLE && (state==IDLE || (state==SHIFT && CNT==0)).
- Load, on handshake edge k:
  - DDR_OUT <= DATA[W-1:W-2]; SR <= DATA<<2; CNT <= CLKDV*2-1; state <= SHIFT; BUSY <= 1.
  - Latency: first pair is visible in cycle k+1.
- SHIFT with CNT>0: DDR_OUT <= SR[W-1:W-2]; SR <= SR<<2; CNT <= CNT-1.
- SHIFT with CNT==0 and handshake: load the next word (seamless back-to-back; no idle pair inserted).
- SHIFT with CNT==0 and no handshake:
  - state <= IDLE; DDR_OUT <= {IDLE_BIT,IDLE_BIT}; BUSY <= 0; UNDERRUN pulses high for exactly one cycle.
  - This also applies when ENABLE is low.
- ENABLE deasserted mid-word: the current word completes, then the block goes idle and pulses UNDERRUN.
- DATA_VALID without ENABLE: word not accepted; DATA_VALID may stay asserted indefinitely with no side effects.
- RST mid-word: the word is aborted; idle pattern appears in the next cycle; no UNDERRUN pulse.
- DATA is sampled only on the handshake edge; changes at any other time are ignored.

Optional Feature:
- Macro: DDR_SER_LSB_FIRST_EN.
- Defined:
  - Load emits {DATA[0],DATA[1]}, then {DATA[2],DATA[3]}, and so on; SR shifts right by 2.
  - DDR_OUT[1] still carries the earlier bit of each pair.
- Undefined: MSB-first ordering as above.
- Handshake, timing and UNDERRUN are identical in both builds.

Decomposition:
- Shared package ddr_pkg holds:
  - State encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - A clog2 function reused by the deserializer side.
- No sub-module; the ODDR primitive is instantiated in the IO wrapper, not here.

Test Plan (CLKDV=4):
- Reset → DDR_OUT=2'b00, BUSY=0, DATA_READY=ENABLE, UNDERRUN=0.
- Single word 0xA5C3 with ENABLE=1 → DDR_OUT sequence 10,10,01,01,11,00,00,11 in cycles k+1..k+8; then 00 with UNDERRUN=1 for one cycle and BUSY=0.
- Back-to-back 0xA5C3 then 0xFFFF, DATA_VALID held high → 16 consecutive pairs with no idle gap; DATA_READY high only in cycle k and cycle k+8; single UNDERRUN after the last 11.
- ENABLE dropped at cycle k+3 during 0x1234 with DATA_VALID=1 → full word 00,01,00,10,00,11,01,00 completes; no second load; UNDERRUN pulses.
- RST asserted at cycle k+4 of 0xA5C3 → DDR_OUT=00 at k+5, BUSY=0, no UNDERRUN; the next word restarts from its MSB pair.
- DDR_SER_LSB_FIRST_EN defined, word 0xA5C3 → 11,00,00,11,10,10,01,01; loopback through the deserializer with the bit order reversed matches.
